// File: rtl/hex_mem_arbiter.sv
// -----------------------------------------------------------------------------
// hex_mem_arbiter
//
// Shares the single-port, word-addressed hex memory between three requesters:
// the host/loader, the processor data path (LDAM/LDBM/STAM/LDAI/LDBI/STAI) and
// instruction fetch. The memory has a synchronous read with one cycle of
// latency, so at most one read is ever in flight; this block remembers which
// port issued it and steers the returning word back to that port only.
//
// Priority is fixed: host > data > fetch. A saturating counter tracks how many
// consecutive cycles fetch has been requesting without a grant; once it
// reaches STARVE_LIMIT, fetch is promoted above data (never above host).
//
// Handshake (all three ports):
//   A requester raises req with its fields and holds them stable until it
//   sees gnt in the same cycle. gnt is combinational from the current req
//   inputs and registered state, and at most one gnt is asserted per cycle.
//   The accepted access is presented to the memory in the grant cycle.
//   Writes complete there and produce no response. A read granted in cycle N
//   returns rvalid=1 with rdata on the issuing port in cycle N+1 only; rdata
//   is zero whenever rvalid is low. Dropping req before gnt is legal and
//   issues nothing.
//
// Ports:
//   i_clk, i_rst          clock; asynchronous active-high reset
//   i_host_*              host request (req/we/addr/wdata)
//   o_host_*              host grant, read valid, read data
//   i_data_*              processor data request (req/we/addr/wdata)
//   o_data_*              data grant, read valid, read data
//   i_fetch_req/addr      instruction fetch read request
//   o_fetch_*             fetch grant, read valid, read data
//   o_mem_en/we/addr/wdata  memory strobe and access fields (0 when idle)
//   i_mem_rdata           memory read data, valid the cycle after a read
//   o_dbg_owner           pending-read owner state (NONE/HOST/DATA/FETCH)
//   o_dbg_starve_cnt      fetch starvation counter
// -----------------------------------------------------------------------------
module hex_mem_arbiter #(
  parameter int ADDR_WIDTH   = 19,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,

  input  logic                  i_host_req,
  input  logic                  i_host_we,
  input  logic [ADDR_WIDTH-1:0] i_host_addr,
  input  logic [DATA_WIDTH-1:0] i_host_wdata,
  output logic                  o_host_gnt,
  output logic                  o_host_rvalid,
  output logic [DATA_WIDTH-1:0] o_host_rdata,

  input  logic                  i_data_req,
  input  logic                  i_data_we,
  input  logic [ADDR_WIDTH-1:0] i_data_addr,
  input  logic [DATA_WIDTH-1:0] i_data_wdata,
  output logic                  o_data_gnt,
  output logic                  o_data_rvalid,
  output logic [DATA_WIDTH-1:0] o_data_rdata,

  input  logic                  i_fetch_req,
  input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
  output logic                  o_fetch_gnt,
  output logic                  o_fetch_rvalid,
  output logic [DATA_WIDTH-1:0] o_fetch_rdata,

  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,

  output logic [1:0]            o_dbg_owner,
  output logic [3:0]            o_dbg_starve_cnt
);

  // Owner of the single outstanding read.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_HOST  = 2'd1,
    OWN_DATA  = 2'd2,
    OWN_FETCH = 2'd3
  } owner_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  owner_t     owner_q;
  owner_t     owner_nxt;
  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_nxt;

  logic       promoted;
  logic       host_win;
  logic       data_win;
  logic       fetch_win;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_q      <= OWN_NONE;
      starve_cnt_q <= 4'd0;
    end else begin
      owner_q      <= owner_nxt;
      starve_cnt_q <= starve_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration and next state
  // ---------------------------------------------------------------------------
  always_comb begin
    host_win       = 1'b0;
    data_win       = 1'b0;
    fetch_win      = 1'b0;
    owner_nxt      = OWN_NONE;
    starve_cnt_nxt = starve_cnt_q;

    promoted = (starve_cnt_q == STARVE_MAX);

    // Grants are suppressed while reset is held so every output reads 0 the
    // instant reset asserts, even if requesters keep their req lines high.
    if (!i_rst) begin
      if (i_host_req) begin
        host_win = 1'b1;
      end else if (i_fetch_req && promoted) begin
        fetch_win = 1'b1;
      end else if (i_data_req) begin
        data_win = 1'b1;
      end else if (i_fetch_req) begin
        fetch_win = 1'b1;
      end
    end

    // Only reads leave something outstanding; a write grant or an idle cycle
    // returns the owner to NONE, which also retires the previous read.
    if (host_win && !i_host_we) begin
      owner_nxt = OWN_HOST;
    end else if (data_win && !i_data_we) begin
      owner_nxt = OWN_DATA;
    end else if (fetch_win) begin
      owner_nxt = OWN_FETCH;
    end

    // Counts consecutive denied fetch cycles, including cycles lost to host
    // while promoted, and holds at the limit so promotion persists until
    // fetch finally wins or withdraws.
    if (!i_fetch_req || fetch_win) begin
      starve_cnt_nxt = 4'd0;
    end else if (starve_cnt_q != STARVE_MAX) begin
      starve_cnt_nxt = starve_cnt_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_host_gnt     = host_win;
    o_data_gnt     = data_win;
    o_fetch_gnt    = fetch_win;

    o_mem_en       = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr     = '0;
    o_mem_wdata    = '0;

    if (host_win) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_host_we;
      o_mem_addr  = i_host_addr;
      o_mem_wdata = i_host_wdata;
    end else if (data_win) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_data_we;
      o_mem_addr  = i_data_addr;
      o_mem_wdata = i_data_wdata;
    end else if (fetch_win) begin
      o_mem_en    = 1'b1;
      o_mem_we    = 1'b0;
      o_mem_addr  = i_fetch_addr;
      o_mem_wdata = '0;
    end

    // The registered owner marks the cycle in which i_mem_rdata carries the
    // word for the read granted one cycle earlier.
    o_host_rvalid  = (owner_q == OWN_HOST);
    o_data_rvalid  = (owner_q == OWN_DATA);
    o_fetch_rvalid = (owner_q == OWN_FETCH);

    o_host_rdata   = o_host_rvalid  ? i_mem_rdata : '0;
    o_data_rdata   = o_data_rvalid  ? i_mem_rdata : '0;
    o_fetch_rdata  = o_fetch_rvalid ? i_mem_rdata : '0;

    o_dbg_owner      = owner_q;
    o_dbg_starve_cnt = starve_cnt_q;
  end

endmodule

// File: tb/tb_hex_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for hex_mem_arbiter. Drivers issue directed requests;
// each expected grant order and each expected read word is hand-written.
// A monitor on the falling edge pops the queues whenever the DUT grants or
// presents read data.
// -----------------------------------------------------------------------------
module tb_hex_mem_arbiter;

  localparam int AW = 19;
  localparam int DW = 32;

  // Port codes used in the scoreboard queues.
  localparam logic [1:0] P_HOST  = 2'd1;
  localparam logic [1:0] P_DATA  = 2'd2;
  localparam logic [1:0] P_FETCH = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;

  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;

  logic          data_req = 1'b0, data_we = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic          data_gnt, data_rvalid;
  logic [DW-1:0] data_rdata;

  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_gnt, fetch_rvalid;
  logic [DW-1:0] fetch_rdata;

  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [1:0]    dbg_owner;
  logic [3:0]    dbg_starve;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected read responses: {due cycle[15:0], port[1:0], data[31:0]}.
  logic [49:0] exp_q[$];
  // Expected grant order, one port code per granted cycle.
  logic [1:0]  exp_gnt_q[$];

  logic [DW-1:0] mem [int];

  hex_mem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(4)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_host_req      (host_req),
    .i_host_we       (host_we),
    .i_host_addr     (host_addr),
    .i_host_wdata    (host_wdata),
    .o_host_gnt      (host_gnt),
    .o_host_rvalid   (host_rvalid),
    .o_host_rdata    (host_rdata),
    .i_data_req      (data_req),
    .i_data_we       (data_we),
    .i_data_addr     (data_addr),
    .i_data_wdata    (data_wdata),
    .o_data_gnt      (data_gnt),
    .o_data_rvalid   (data_rvalid),
    .o_data_rdata    (data_rdata),
    .i_fetch_req     (fetch_req),
    .i_fetch_addr    (fetch_addr),
    .o_fetch_gnt     (fetch_gnt),
    .o_fetch_rvalid  (fetch_rvalid),
    .o_fetch_rdata   (fetch_rdata),
    .o_mem_en        (mem_en),
    .o_mem_we        (mem_we),
    .o_mem_addr      (mem_addr),
    .o_mem_wdata     (mem_wdata),
    .i_mem_rdata     (mem_rdata),
    .o_dbg_owner     (dbg_owner),
    .o_dbg_starve_cnt(dbg_starve)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset / memory model
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[int'(mem_addr)] = mem_wdata;
      else        mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 32'hDEAD_BEEF;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks: entered and left just after a rising edge
  // ---------------------------------------------------------------------------
  task automatic check_grant(input logic [1:0] port, input logic we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input logic [DW-1:0] exp_rd);
    checks++;
    if (!(mem_en === 1'b1 && mem_we === we && mem_addr === addr &&
          (we ? (mem_wdata === wdata) : 1'b1))) begin
      errors++;
      $display("FAIL mem_access port=%0d got en=%b we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
               port, mem_en, mem_we, mem_addr, mem_wdata, we, addr, wdata);
    end
    if (!we) exp_q.push_back({16'(cyc + 1), port, exp_rd});
  endtask

  task automatic host_acc(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd);
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (host_gnt) break;
    end
    if (host_gnt) check_grant(P_HOST, we, addr, wdata, exp_rd);
    else begin
      checks++; errors++;
      $display("FAIL host_timeout got gnt=0 want gnt=1 addr=%h", addr);
    end
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  task automatic data_acc(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd);
    data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (data_gnt) break;
    end
    if (data_gnt) check_grant(P_DATA, we, addr, wdata, exp_rd);
    else begin
      checks++; errors++;
      $display("FAIL data_timeout got gnt=0 want gnt=1 addr=%h", addr);
    end
    @(posedge clk); #1;
    data_req = 1'b0;
  endtask

  task automatic fetch_acc(input logic [AW-1:0] addr, input logic [DW-1:0] exp_rd);
    fetch_req = 1'b1; fetch_addr = addr;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (fetch_gnt) break;
    end
    if (fetch_gnt) check_grant(P_FETCH, 1'b0, addr, '0, exp_rd);
    else begin
      checks++; errors++;
      $display("FAIL fetch_timeout got gnt=0 want gnt=1 addr=%h", addr);
    end
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [255:0] all_outputs();
    return 256'({host_gnt, host_rvalid, host_rdata, data_gnt, data_rvalid, data_rdata,
                 fetch_gnt, fetch_rvalid, fetch_rdata, mem_en, mem_we, mem_addr,
                 mem_wdata, dbg_owner, dbg_starve});
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      int n_gnt;
      logic [1:0] g;
      n_gnt = int'(host_gnt) + int'(data_gnt) + int'(fetch_gnt);
      g = host_gnt ? P_HOST : (data_gnt ? P_DATA : P_FETCH);
      if (n_gnt > 0) begin
        checks++;
        if (n_gnt > 1) begin
          errors++;
          $display("FAIL gnt_onehot got %0d grants want 1", n_gnt);
        end else if (exp_gnt_q.size() == 0) begin
          errors++;
          $display("FAIL gnt_unexpected got port %0d want none", g);
        end else begin
          logic [1:0] e;
          e = exp_gnt_q.pop_front();
          if (e !== g) begin
            errors++;
            $display("FAIL gnt_order got port %0d want port %0d (cycle %0d)", g, e, cyc);
          end
        end
      end

      if (exp_q.size() > 0 && exp_q[0][49:34] == 16'(cyc)) begin
        logic [49:0] e;
        logic [2:0]  rv_want;
        logic [DW-1:0] rd_got;
        e = exp_q.pop_front();
        rv_want = (e[33:32] == P_HOST)  ? 3'b100 :
                  (e[33:32] == P_DATA)  ? 3'b010 : 3'b001;
        rd_got  = (e[33:32] == P_HOST)  ? host_rdata :
                  (e[33:32] == P_DATA)  ? data_rdata : fetch_rdata;
        checks++;
        if ({host_rvalid, data_rvalid, fetch_rvalid} !== rv_want || rd_got !== e[31:0]) begin
          errors++;
          $display("FAIL rvalid_data got rv=%b rdata=%h want rv=%b rdata=%h (cycle %0d)",
                   {host_rvalid, data_rvalid, fetch_rvalid}, rd_got, rv_want, e[31:0], cyc);
        end
      end else if (host_rvalid || data_rvalid || fetch_rvalid) begin
        checks++; errors++;
        $display("FAIL rvalid_spurious got rv=%b want 000 (cycle %0d)",
                 {host_rvalid, data_rvalid, fetch_rvalid}, cyc);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [DW-1:0] b2b_tbl [8];
    int c0;

    b2b_tbl = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003,
                32'hC0DE_0004, 32'hC0DE_0005, 32'hC0DE_0006, 32'hC0DE_0007};
    for (int i = 0; i < 8; i++) mem[i] = b2b_tbl[i];
    mem['h10]  = 32'hE3D1_0000;
    mem['h20]  = 32'h5A5A_0020;
    mem['h21]  = 32'h5A5A_0021;
    mem['h100] = 32'h1111_1111;
    mem['h200] = 32'h2222_2222;
    mem['h300] = 32'h3333_3333;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", 64'(all_outputs() != 0), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single fetch read.
    exp_gnt_q.push_back(P_FETCH);
    fetch_acc(19'h00010, 32'hE3D1_0000);

    // Data write then data read of the top word.
    exp_gnt_q.push_back(P_DATA);
    exp_gnt_q.push_back(P_DATA);
    data_acc(1'b1, 19'h7FFFF, 32'h1234_5678, '0);
    data_acc(1'b0, 19'h7FFFF, '0, 32'h1234_5678);

    // All three at once: host, data, fetch in order.
    exp_gnt_q.push_back(P_HOST);
    exp_gnt_q.push_back(P_DATA);
    exp_gnt_q.push_back(P_FETCH);
    fork
      host_acc(1'b0, 19'h00100, '0, 32'h1111_1111);
      data_acc(1'b0, 19'h00200, '0, 32'h2222_2222);
      fetch_acc(19'h00300, 32'h3333_3333);
    join
    @(posedge clk); #1;

    // Continuous data writes with fetch pending: fetch wins on the 5th cycle.
    for (int i = 0; i < 4; i++) exp_gnt_q.push_back(P_DATA);
    exp_gnt_q.push_back(P_FETCH);
    exp_gnt_q.push_back(P_DATA);
    exp_gnt_q.push_back(P_DATA);
    c0 = cyc;
    fork
      for (int i = 0; i < 6; i++) data_acc(1'b1, 19'(32'h1000 + i), 32'hAB00_0000 + i, '0);
      begin
        fetch_acc(19'h00020, 32'h5A5A_0020);
        check_val("fetch_promoted_cycle", 64'(cyc - c0), 64'd5);
        check_val("starve_cleared", 64'(dbg_starve), 64'd0);
      end
    join
    @(posedge clk); #1;

    // Same pattern with host arriving in the promoted cycle: host still wins.
    for (int i = 0; i < 4; i++) exp_gnt_q.push_back(P_DATA);
    exp_gnt_q.push_back(P_HOST);
    exp_gnt_q.push_back(P_FETCH);
    exp_gnt_q.push_back(P_DATA);
    exp_gnt_q.push_back(P_DATA);
    c0 = cyc;
    fork
      for (int i = 0; i < 6; i++) data_acc(1'b1, 19'(32'h1100 + i), 32'hCD00_0000 + i, '0);
      begin
        fetch_acc(19'h00021, 32'h5A5A_0021);
        check_val("fetch_after_host_cycle", 64'(cyc - c0), 64'd6);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        check_val("starve_saturated", 64'(dbg_starve), 64'd4);
        host_acc(1'b1, 19'h02000, 32'hBBBB_0001, '0);
      end
    join
    @(posedge clk); #1;

    // Back-to-back fetch reads of 0..7.
    for (int i = 0; i < 8; i++) exp_gnt_q.push_back(P_FETCH);
    c0 = cyc;
    for (int i = 0; i < 8; i++) fetch_acc(19'(i), b2b_tbl[i]);
    check_val("b2b_grant_span", 64'(cyc - c0), 64'd8);
    @(posedge clk); #1;

    // Asynchronous reset while a read is outstanding.
    exp_gnt_q.push_back(P_FETCH);
    fetch_req = 1'b1; fetch_addr = 19'h00010;
    @(negedge clk);
    check_val("rst_pre_gnt", 64'(fetch_gnt), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_val("rst_async_outputs", 64'(all_outputs() != 0), 64'd0);
    fetch_req = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_no_rvalid", 64'({host_rvalid, data_rvalid, fetch_rvalid}), 64'd0);
    @(posedge clk); #1;
    exp_gnt_q.push_back(P_FETCH);
    fetch_acc(19'h00010, 32'hE3D1_0000);

    repeat (3) @(negedge clk);
    check_val("exp_rd_drained", 64'(exp_q.size()), 64'd0);
    check_val("exp_gnt_drained", 64'(exp_gnt_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hex_mem_arbiter.md
Name: hex_mem_arbiter

Overview:
- Shares the single-port, word-addressed hex memory (2^19 x 32-bit words, synchronous read, 1-cycle latency) between three requesters: host/loader, processor data access (LDAM/LDBM/STAM/LDAI/LDBI/STAI), and instruction fetch.
- Sits between the processor core and the memory macro.
- Fixed priority, host > data > fetch, with an anti-starvation promotion for fetch.
- Tracks the one outstanding read and routes its data back to the port that issued it.

Parameters:
- ADDR_WIDTH, 19, word address width (MEM_ADDR_WIDTH-2).
- DATA_WIDTH, 32, memory word width.
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is promoted above data. Legal range 1..15.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_host_req  in  1  host request
- i_host_we  in  1  host write enable (1=write, 0=read)
- i_host_addr  in  ADDR_WIDTH  host word address
- i_host_wdata  in  DATA_WIDTH  host write data
- o_host_gnt  out  1  host request accepted this cycle
- o_host_rvalid  out  1  host read data valid
- o_host_rdata  out  DATA_WIDTH  host read data
- i_data_req, i_data_we, i_data_addr, i_data_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  data port request, same meaning as host
- o_data_gnt, o_data_rvalid, o_data_rdata  out  1/1/DATA_WIDTH  data port responses, same meaning as host
- i_fetch_req  in  1  fetch read request (read-only port)
- i_fetch_addr  in  ADDR_WIDTH  fetch word address
- o_fetch_gnt, o_fetch_rvalid, o_fetch_rdata  out  1/1/DATA_WIDTH  fetch port responses
- o_mem_en  out  1  memory access strobe
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_WIDTH  memory word address
- o_mem_wdata  out  DATA_WIDTH  memory write data
- i_mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read strobe

Behaviour:
- Clock and reset: single clock i_clk. i_rst is asynchronous and active-high.
- Reset values: all outputs 0; starvation counter 0; pending-read owner NONE.
- Request rule:
  - A requester holds req, and all its fields stable, until it sees gnt.
  - Dropping req before gnt is legal; nothing is issued.
- Grant logic:
  - gnt is combinational from current req and registered state.
  - At most one gnt per cycle.
  - In a grant cycle: o_mem_en=1, and o_mem_we/addr/wdata are muxed from the winner. When no grant, o_mem_en=0 and the other mem outputs are don't-care (drive 0).
- Priority:
  - Host first.
  - Then fetch, if the promoted flag (starve_cnt == STARVE_LIMIT) is set.
  - Then data.
  - Then fetch.
- Writes: complete in the grant cycle. No rvalid is produced.
- Read latency:
  - A read granted in cycle N gives rvalid=1 on the owning port only, in cycle N+1.
  - rdata = i_mem_rdata in that cycle; each rdata is valid only with its rvalid.
  - Owner is registered in a 2-bit state: NONE / HOST / DATA / FETCH.
- Pipelining: a new grant may issue in the same cycle as a previous read's rvalid. Back-to-back reads give 1 word per cycle.
- Starvation counter (saturating, 4 bits):
  - Increments each cycle i_fetch_req=1 and o_fetch_gnt=0.
  - Clears to 0 on a fetch grant or when i_fetch_req=0.
  - Saturates at STARVE_LIMIT.
  - Host is never preempted by promotion.
- Simultaneous events: host+data+fetch all requesting gives a host grant. The fetch counter still increments.
- Reset mid-operation: an outstanding read is discarded, and no rvalid appears after reset deasserts.
- Address/width: addresses pass through unmodified (no byte-to-word conversion here; the core supplies word addresses).

Test Plan:
- Reset, then a single fetch read of addr 0x00010 with mem word 0xE3D10000 -> o_fetch_gnt=1 in cycle 0; o_fetch_rvalid=1 and rdata=0xE3D10000 in cycle 1; all other rvalids stay 0.
- Data write 0x12345678 to 0x7FFFF, then data read of 0x7FFFF on the next cycle -> mem_we=1 then mem_we=0; data rvalid with 0x12345678 one cycle after the read grant.
- Host, data and fetch all requesting in the same cycle -> order of grants host, data, fetch on consecutive cycles; each rvalid lands on the correct port one cycle after its grant.
- Data requests continuously with fetch pending and STARVE_LIMIT=4 -> data granted for 4 cycles, fetch granted on cycle 5, counter back to 0; host request in the promoted cycle still wins.
- Back-to-back fetch reads of 0x0..0x7 -> 8 grants on 8 consecutive cycles; 8 rvalids on the following consecutive cycles with matching data.
- Read granted, then i_rst pulsed asynchronously mid-cycle before rvalid -> all outputs 0 immediately; no rvalid after release; next request is granted normally.
